// File: rtl/cpu_step_monitor.sv
// -----------------------------------------------------------------------------
// cpu_step_monitor
//
// Front panel for single-stepping a small CPU on an FPGA board. A raw push
// button is synchronised and debounced, and each debounced press issues CPU
// clock-enable pulses according to the selected mode: one pulse, a burst of
// BURST_LEN pulses, or continuous free-run. The cycle after every pulse the CPU
// result and flags are captured into a small circular history buffer, and any
// history entry can be viewed one byte at a time on the LEDs.
//
// Parameters
//   DATA_W     monitored result width (multiple of 8)
//   DEPTH      history entries (power of 2, >= 2)
//   DEB_CYCLES cycles the synchronised button must stay changed to be accepted
//   BURST_LEN  pulses issued per burst (>= 1)
//
// Ports
//   clk_100MHz  in   system clock, all logic on the rising edge
//   rst         in   asynchronous active-low reset (release is synchronised)
//   step_btn    in   raw, unsynchronised push button
//   mode        in   00 single-step, 01 burst, 10 free-run, 11 halt
//   cpu_result  in   CPU ALU result
//   cpu_zf      in   CPU zero flag
//   cpu_of      in   CPU overflow flag
//   byte_sel    in   LED view: result byte index, DATA_W/8 = flags, above = 0
//   hist_sel    in   history entry, 0 = most recent capture
//   cpu_step    out  registered one-cycle CPU clock-enable pulse
//   busy        out  high while bursting or free-running
//   step_cnt    out  number of cpu_step pulses issued (wraps)
//   LED         out  registered display byte
// -----------------------------------------------------------------------------
module cpu_step_monitor #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 8,
  parameter int DEB_CYCLES = 1000000,
  parameter int BURST_LEN  = 16
) (
  input  logic                        clk_100MHz,
  input  logic                        rst,
  input  logic                        step_btn,
  input  logic [1:0]                  mode,
  input  logic [DATA_W-1:0]           cpu_result,
  input  logic                        cpu_zf,
  input  logic                        cpu_of,
  input  logic [$clog2(DATA_W/8):0]   byte_sel,
  input  logic [$clog2(DEPTH)-1:0]    hist_sel,
  output logic                        cpu_step,
  output logic                        busy,
  output logic [15:0]                 step_cnt,
  output logic [7:0]                  LED
);

  localparam int NB    = DATA_W / 8;
  localparam int BS_W  = $clog2(NB) + 1;
  localparam int HS_W  = $clog2(DEPTH);
  localparam int VC_W  = HS_W + 1;
  localparam int DC_W  = $clog2(DEB_CYCLES + 1);
  localparam int BC_W  = $clog2(BURST_LEN + 1);
  localparam int ENT_W = DATA_W + 2;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_BURST  = 2'b01;
  localparam logic [1:0] MODE_RUN    = 2'b10;

  localparam logic [DC_W-1:0] DEB_LAST   = DC_W'(DEB_CYCLES - 1);
  localparam logic [BC_W-1:0] BURST_LOAD = BC_W'(BURST_LEN - 1);
  localparam logic [VC_W-1:0] VLD_FULL   = VC_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_BURST  = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  // Display view of one history entry {of, zf, result}: a result byte, the
  // flag byte {OF,000000,ZF}, or zero for out-of-range selections.
  function automatic logic [7:0] view_byte(input logic [ENT_W-1:0] entry,
                                           input logic [BS_W-1:0]  sel);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (sel == BS_W'(i)) v = entry[i*8 +: 8];
    end
    if (sel == BS_W'(NB)) v = {entry[ENT_W-1], 6'b000000, entry[ENT_W-2]};
    return v;
  endfunction

  // Reset synchroniser: assertion passes straight through, release waits two
  // edges so no flop leaves reset on an edge close to the rst transition.
  logic rst_meta;
  logic rst_sync;

  always_ff @(posedge clk_100MHz or negedge rst) begin
    if (!rst) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  // Stage p0: button synchroniser and debounce
  logic            btn_meta;
  logic            btn_sync;
  logic            deb_level;
  logic            deb_prev;
  logic [DC_W-1:0] deb_cnt;
  logic            press;

  always_ff @(posedge clk_100MHz or negedge rst_sync) begin
    if (!rst_sync) begin
      btn_meta  <= 1'b0;
      btn_sync  <= 1'b0;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      btn_meta <= step_btn;
      btn_sync <= btn_meta;
      deb_prev <= deb_level;
      // Any sample that agrees with the accepted level restarts the count,
      // so a bounce shorter than DEB_CYCLES never reaches the FSM.
      if (btn_sync == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_level <= btn_sync;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // One-cycle event on the debounced rising edge only.
  assign press = deb_level & ~deb_prev;

  // Stage p1: step FSM
  state_t          state;
  state_t          next_state;
  logic            step_nxt;
  logic [BC_W-1:0] burst_cnt;
  logic [BC_W-1:0] burst_nxt;

  // burst_cnt holds the pulses still to come after the one currently on
  // cpu_step. Entering BURST loads BURST_LEN and immediately spends one on
  // the first pulse, which goes out together with the state change.
  always_ff @(posedge clk_100MHz or negedge rst_sync) begin
    if (!rst_sync) begin
      state     <= ST_IDLE;
      cpu_step  <= 1'b0;
      burst_cnt <= '0;
      step_cnt  <= 16'h0000;
    end else begin
      state     <= next_state;
      cpu_step  <= step_nxt;
      burst_cnt <= burst_nxt;
      if (step_nxt) step_cnt <= step_cnt + 16'd1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (mode == MODE_RUN)                   next_state = ST_RUN;
        else if (press && mode == MODE_SINGLE)  next_state = ST_SINGLE;
        else if (press && mode == MODE_BURST)   next_state = ST_BURST;
      end
      ST_SINGLE: next_state = ST_IDLE;
      ST_BURST: begin
        if (mode != MODE_BURST || burst_cnt == '0) next_state = ST_IDLE;
      end
      ST_RUN: begin
        if (mode != MODE_RUN) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Pulses are decided one cycle ahead so cpu_step comes straight from a flop
  // and appears the cycle after the press event. Presses outside IDLE are not
  // looked at, so they are dropped rather than queued.
  always_comb begin
    step_nxt  = 1'b0;
    burst_nxt = burst_cnt;
    case (state)
      ST_IDLE: begin
        if (mode == MODE_RUN) begin
          step_nxt = 1'b1;
        end else if (press && mode == MODE_SINGLE) begin
          step_nxt = 1'b1;
        end else if (press && mode == MODE_BURST) begin
          step_nxt  = 1'b1;
          burst_nxt = BURST_LOAD;
        end
      end
      ST_BURST: begin
        if (mode == MODE_BURST && burst_cnt != '0) begin
          step_nxt  = 1'b1;
          burst_nxt = burst_cnt - 1'b1;
        end else begin
          burst_nxt = '0;
        end
      end
      ST_RUN: begin
        if (mode == MODE_RUN) step_nxt = 1'b1;
      end
      default: begin
        step_nxt  = 1'b0;
        burst_nxt = '0;
      end
    endcase
  end

  assign busy = (state == ST_BURST) || (state == ST_RUN);

  // Stage p2: history capture, the cycle after each pulse
  logic             cap_vld_p2;
  logic [HS_W-1:0]  wr_ptr;
  logic [VC_W-1:0]  vld_cnt;
  logic [ENT_W-1:0] hist_mem [DEPTH];

  always_ff @(posedge clk_100MHz or negedge rst_sync) begin
    if (!rst_sync) begin
      cap_vld_p2 <= 1'b0;
      wr_ptr     <= '0;
      vld_cnt    <= '0;
    end else begin
      cap_vld_p2 <= cpu_step;
      if (cap_vld_p2) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (vld_cnt != VLD_FULL) vld_cnt <= vld_cnt + 1'b1;
      end
    end
  end

  // Entry storage is left out of reset; a zero valid count hides stale data.
  always_ff @(posedge clk_100MHz) begin
    if (cap_vld_p2) hist_mem[wr_ptr] <= {cpu_of, cpu_zf, cpu_result};
  end

  // Stage p3: history read and LED register
  logic [HS_W-1:0]  rd_idx_p3;
  logic             rd_hit_p3;
  logic [ENT_W-1:0] rd_entry_p3;

  always_comb begin
    rd_idx_p3   = wr_ptr - HS_W'(1) - hist_sel;
    rd_hit_p3   = {1'b0, hist_sel} < vld_cnt;
    rd_entry_p3 = rd_hit_p3 ? hist_mem[rd_idx_p3] : '0;
  end

  always_ff @(posedge clk_100MHz or negedge rst_sync) begin
    if (!rst_sync) begin
      LED <= 8'h00;
    end else begin
      LED <= view_byte(rd_entry_p3, byte_sel);
    end
  end

endmodule

// File: tb/tb_cpu_step_monitor.sv
module tb_cpu_step_monitor;

  localparam int DATA_W     = 32;
  localparam int DEPTH      = 4;
  localparam int DEB_CYCLES = 4;
  localparam int BURST_LEN  = 3;

  logic        clk_100MHz;
  logic        rst;
  logic        step_btn;
  logic [1:0]  mode;
  logic [31:0] cpu_result;
  logic        cpu_zf;
  logic        cpu_of;
  logic [2:0]  byte_sel;
  logic [1:0]  hist_sel;
  logic        cpu_step;
  logic        busy;
  logic [15:0] step_cnt;
  logic [7:0]  LED;

  cpu_step_monitor #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .DEB_CYCLES (DEB_CYCLES),
    .BURST_LEN  (BURST_LEN)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .step_btn   (step_btn),
    .mode       (mode),
    .cpu_result (cpu_result),
    .cpu_zf     (cpu_zf),
    .cpu_of     (cpu_of),
    .byte_sel   (byte_sel),
    .hist_sel   (hist_sel),
    .cpu_step   (cpu_step),
    .busy       (busy),
    .step_cnt   (step_cnt),
    .LED        (LED)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  int n_total = 0;
  int n_pass  = 0;

  // Pulse / busy bookkeeping sampled on the falling edge.
  int pulses   = 0;
  int busy_cyc = 0;
  int run_len  = 0;
  int last_run = 0;

  always @(negedge clk_100MHz) begin
    if (cpu_step) begin
      pulses  = pulses + 1;
      run_len = run_len + 1;
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
    if (busy) busy_cyc = busy_cyc + 1;
  end

  typedef struct {
    int         phase;
    logic [1:0] hs;
    logic [2:0] bs;
    logic [7:0] exp;
  } view_vec_t;

  view_vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic press_btn(input bit bounce, input int hold);
    if (bounce) begin
      step_btn = 1'b1;
      wait_cyc(1);
      step_btn = 1'b0;
      wait_cyc(1);
    end
    step_btn = 1'b1;
    wait_cyc(hold);
    step_btn = 1'b0;
    wait_cyc(12);
  endtask

  task automatic do_step(input logic [31:0] res, input logic of, input logic zf);
    cpu_result = res;
    cpu_of     = of;
    cpu_zf     = zf;
    mode       = 2'b00;
    press_btn(1'b0, 10);
  endtask

  task automatic do_reset();
    @(negedge clk_100MHz);
    rst = 1'b0;
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(4);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p0;
    int b0;
    bit got;

    // hist_sel, byte_sel -> LED after the first two captures (phase 1)
    // and after six captures with wrap (phase 2).
    vecs[0]  = '{1, 2'd1, 3'd1, 8'h33};
    vecs[1]  = '{1, 2'd0, 3'd1, 8'h77};
    vecs[2]  = '{1, 2'd2, 3'd1, 8'h00};
    vecs[3]  = '{1, 2'd0, 3'd0, 8'h88};
    vecs[4]  = '{1, 2'd1, 3'd3, 8'h11};
    vecs[5]  = '{1, 2'd0, 3'd4, 8'h01};
    vecs[6]  = '{1, 2'd1, 3'd4, 8'h00};
    vecs[7]  = '{1, 2'd0, 3'd5, 8'h00};
    vecs[8]  = '{2, 2'd0, 3'd4, 8'h81};
    vecs[9]  = '{2, 2'd0, 3'd0, 8'hBE};
    vecs[10] = '{2, 2'd3, 3'd0, 8'hCC};
    vecs[11] = '{2, 2'd3, 3'd3, 8'h99};
    vecs[12] = '{2, 2'd2, 3'd2, 8'hEE};
    vecs[13] = '{2, 2'd1, 3'd1, 8'h2D};
    vecs[14] = '{2, 2'd0, 3'd7, 8'h00};
    vecs[15] = '{2, 2'd2, 3'd4, 8'h80};

    rst        = 1'b1;
    step_btn   = 1'b0;
    mode       = 2'b11;
    cpu_result = 32'h0;
    cpu_zf     = 1'b0;
    cpu_of     = 1'b0;
    byte_sel   = 3'd0;
    hist_sel   = 2'd0;
    #3 rst = 1'b0;
    wait_cyc(2);

    // Reset state
    check("reset_cpu_step", 32'(cpu_step), 32'd0);
    check("reset_busy",     32'(busy),     32'd0);
    check("reset_step_cnt", 32'(step_cnt), 32'd0);
    check("reset_led",      32'(LED),      32'd0);
    rst = 1'b1;
    wait_cyc(4);

    // Single step with a short bounce before the real press
    mode = 2'b00;
    p0 = pulses;
    press_btn(1'b1, 10);
    check("single_pulses",   32'(pulses - p0), 32'd1);
    check("single_run_len",  32'(last_run),    32'd1);
    check("single_step_cnt", 32'(step_cnt),    32'd1);

    // Burst of BURST_LEN pulses
    mode = 2'b01;
    p0 = pulses;
    b0 = busy_cyc;
    press_btn(1'b0, 10);
    check("burst_pulses",   32'(pulses - p0),   32'd3);
    check("burst_run_len",  32'(last_run),      32'd3);
    check("burst_busy_cyc", 32'(busy_cyc - b0), 32'd3);
    check("burst_step_cnt", 32'(step_cnt),      32'd4);

    // Free-run for 10 cycles with a press arriving mid-run; the press must
    // not fire a single step once the run ends.
    mode = 2'b10;
    step_btn = 1'b1;
    wait_cyc(10);
    mode = 2'b11;
    wait_cyc(2);
    mode = 2'b00;
    step_btn = 1'b0;
    p0 = pulses;
    wait_cyc(12);
    check("run_press_ignored", 32'(pulses - p0), 32'd0);
    check("run_run_len",       32'(last_run),    32'd10);
    check("run_step_cnt",      32'(step_cnt),    32'd14);

    // Burst aborted by a mode change during the first pulse
    mode = 2'b01;
    p0 = pulses;
    step_btn = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_100MHz);
      if (cpu_step) begin
        got = 1'b1;
        break;
      end
    end
    check("abort_first_pulse_seen", 32'(got), 32'd1);
    mode = 2'b11;
    @(negedge clk_100MHz);
    check("abort_step_low", 32'(cpu_step), 32'd0);
    check("abort_busy_low", 32'(busy),     32'd0);
    step_btn = 1'b0;
    wait_cyc(12);
    check("abort_pulses",   32'(pulses - p0), 32'd1);
    check("abort_step_cnt", 32'(step_cnt),    32'd15);

    // History buffer after two captures
    do_reset();
    do_step(32'h11223344, 1'b0, 1'b0);
    do_step(32'h55667788, 1'b0, 1'b1);
    check("hist_step_cnt", 32'(step_cnt), 32'd2);
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].phase == 1) begin
        hist_sel = vecs[i].hs;
        byte_sel = vecs[i].bs;
        @(negedge clk_100MHz);
        check($sformatf("view_%0d_h%0d_b%0d", i, vecs[i].hs, vecs[i].bs),
              32'(LED), 32'(vecs[i].exp));
      end
    end

    // Four more captures: six total, buffer wrapped
    do_step(32'h99AABBCC, 1'b0, 1'b0);
    do_step(32'hDDEEFF00, 1'b1, 1'b0);
    do_step(32'h0F1E2D3C, 1'b0, 1'b0);
    do_step(32'hCAFEBABE, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].phase == 2) begin
        hist_sel = vecs[i].hs;
        byte_sel = vecs[i].bs;
        @(negedge clk_100MHz);
        check($sformatf("view_%0d_h%0d_b%0d", i, vecs[i].hs, vecs[i].bs),
              32'(LED), 32'(vecs[i].exp));
      end
    end

    // Reset in the middle of a free run
    cpu_result = 32'hA5A5A5A5;
    cpu_of     = 1'b0;
    cpu_zf     = 1'b0;
    byte_sel   = 3'd0;
    hist_sel   = 2'd0;
    mode       = 2'b10;
    wait_cyc(5);
    check("midrun_busy", 32'(busy), 32'd1);
    check("midrun_led",  32'(LED),  32'hA5);
    #1 rst = 1'b0;
    #1;
    check("rst_cpu_step", 32'(cpu_step), 32'd0);
    check("rst_step_cnt", 32'(step_cnt), 32'd0);
    check("rst_led",      32'(LED),      32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    mode = 2'b11;
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(4);
    check("post_rst_led_empty", 32'(LED),      32'd0);
    check("post_rst_step_cnt",  32'(step_cnt), 32'd0);

    // Reset release is synchronised: free-run starts on the third edge
    rst  = 1'b0;
    mode = 2'b10;
    wait_cyc(1);
    rst = 1'b1;
    @(negedge clk_100MHz);
    check("release_edge1_step", 32'(cpu_step), 32'd0);
    @(negedge clk_100MHz);
    check("release_edge2_step", 32'(cpu_step), 32'd0);
    @(negedge clk_100MHz);
    check("release_edge3_step", 32'(cpu_step), 32'd1);
    mode = 2'b11;
    wait_cyc(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu_step_monitor.md
CPU_STEP_MONITOR -- requirements
Module: cpu_step_monitor

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, monitored result width (multiple of 8); DEPTH, default 8, history entries (power of 2, >=2); DEB_CYCLES, default 1000000, debounce stable count; BURST_LEN, default 16, steps per burst (>=1).
REQ-002 clk_100MHz  in  1  single system clock; all logic on its rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 step_btn  in  1  raw, unsynchronised push-button.
REQ-005 mode  in  2  00 single-step, 01 burst, 10 free-run, 11 halt.
REQ-006 cpu_result  in  DATA_W  CPU ALU result.
REQ-007 cpu_zf, cpu_of  in  1 each  CPU zero and overflow flags.
REQ-008 byte_sel  in  clog2(DATA_W/8)+1  display view select.
REQ-009 hist_sel  in  clog2(DEPTH)  history entry select; 0 = most recent.
REQ-010 cpu_step  out  1  one-cycle CPU clock-enable pulse.
REQ-011 busy  out  1  high while in BURST or RUN.
REQ-012 step_cnt  out  16  total cpu_step pulses issued.
REQ-013 LED  out  8  registered display byte.

Function
REQ-014 step_btn SHALL pass a 2-flop synchroniser; the debounced level SHALL change only after the synchronised input differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-015 A press event SHALL be a single-cycle pulse on the debounced rising edge; release generates no event.
REQ-016 FSM states SHALL be IDLE, SINGLE, BURST, RUN.
REQ-017 IDLE: press with mode=00 -> SINGLE; press with mode=01 -> BURST with burst counter loaded to BURST_LEN; mode=10 -> RUN (no press required); mode=11 or no press -> stay.
REQ-018 SINGLE SHALL assert cpu_step for exactly one cycle, then return to IDLE.
REQ-019 BURST SHALL assert cpu_step every cycle, decrement the counter per pulse, and return to IDLE after exactly BURST_LEN pulses.
REQ-020 RUN SHALL assert cpu_step every cycle while mode=10; any other mode value -> IDLE, no pulse that cycle.
REQ-021 Press events in SINGLE, BURST or RUN SHALL be ignored (not queued).
REQ-022 In BURST, mode changing away from 01 SHALL abort: no pulse that cycle, go IDLE, counter cleared.
REQ-023 cpu_step SHALL be a registered output; press-to-pulse latency is one cycle after the press event.
REQ-024 The cycle after each cpu_step pulse, {cpu_of, cpu_zf, cpu_result} SHALL be written to a DEPTH-entry circular buffer at the write pointer, which then increments modulo DEPTH.
REQ-025 A valid count SHALL saturate at DEPTH; the entry selected by hist_sel SHALL be the hist_sel-th previous capture (wr_ptr-1-hist_sel mod DEPTH) when hist_sel < valid count, else all-zero.
REQ-026 LED SHALL update one cycle after its inputs: byte_sel < DATA_W/8 -> byte byte_sel of selected entry's result; byte_sel = DATA_W/8 -> {OF,6'b0,ZF} of selected entry; larger -> 8'h00.
REQ-027 step_cnt SHALL increment on each cpu_step pulse and wrap 16'hFFFF -> 0.
REQ-028 A capture and a hist_sel/byte_sel change in the same cycle SHALL show the post-capture buffer on LED one cycle later.

Reset
REQ-029 rst low SHALL immediately force: FSM IDLE, cpu_step 0, busy 0, step_cnt 0, LED 8'h00, write pointer 0, valid count 0, debounced level 0, debounce counter 0, burst counter 0.
REQ-030 Reset mid-burst SHALL abort with no further pulses; buffer contents need not clear but SHALL read as zero via valid count 0.
REQ-031 Release of rst SHALL be synchronised so first state change occurs no earlier than the second clock edge after release.

Verification (bench uses DEB_CYCLES=4, BURST_LEN=3, DEPTH=4, DATA_W=32)
REQ-032 mode=00, button held 10 cycles with 2-cycle bounce at start -> exactly one cpu_step pulse, step_cnt=1.
REQ-033 mode=01, press -> 3 consecutive pulses, busy high 3 cycles; second press during burst -> no extra pulses, step_cnt=3.
REQ-034 mode=01 press, mode->11 after first pulse -> total 1 pulse, busy low next cycle.
REQ-035 cpu_result=0x11223344,0x55667788 captured in order, byte_sel=1, hist_sel=1 -> LED=0x33; hist_sel=0 -> 0x77; hist_sel=2 -> 0x00.
REQ-036 Six captures with cpu_of=1,cpu_zf=1 on last, byte_sel=4, hist_sel=0 -> LED=0x81; hist_sel=3 returns 3rd capture (wrap verified).
REQ-037 mode=10 for 5 cycles then rst low mid-run -> cpu_step, step_cnt, LED, busy all 0 immediately.
